// File: rtl/gpu_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_regs_pkg
// Description : Shared definitions for the GPU control register file:
//               register offsets, CTRL/STATUS bit positions, AXI response
//               codes, default ID value and a byte-lane merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_regs_pkg;

  // Byte offsets of the mapped registers
  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_STATUS      = 8'h04;
  localparam logic [7:0] REG_TRI_COUNT   = 8'h08;
  localparam logic [7:0] REG_VERTEX_BASE = 8'h0C;
  localparam logic [7:0] REG_COLOR_BASE  = 8'h10;
  localparam logic [7:0] REG_ID          = 8'h14;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_SLVERR = 2'b10
  } axi_resp_e;

  localparam logic [31:0] DEFAULT_ID = 32'h4753_0001;

  // Replace only the byte lanes selected by strb
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ctrl_regs
// Description : AXI4-lite register file and frame sequencer. Holds the frame
//               configuration, launches frames with a one-cycle pulse, tracks
//               BUSY/DONE against frame_end and drives a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ctrl_regs
  import gpu_regs_pkg::*;
#(
  parameter int          SADDR_WIDTH = 32,
  parameter int          MADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  // write address
  input  logic [SADDR_WIDTH-1:0] awaddr_i,
  input  logic [2:0]             awprot_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  // write data
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  // write response
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  // read address
  input  logic [SADDR_WIDTH-1:0] araddr_i,
  input  logic [2:0]             arprot_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  // read data
  output logic [31:0]            rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  // pipeline side
  output logic                   frame_start_o,
  input  logic                   frame_end_i,
  output logic [31:0]            triangles_count_o,
  output logic [MADDR_WIDTH-1:0] base_addr_vertex_o,
  output logic [MADDR_WIDTH-1:0] base_addr_color_o,
  output logic                   irq_o
);

  localparam logic [5:0] IDX_CTRL   = REG_CTRL[7:2];
  localparam logic [5:0] IDX_STATUS = REG_STATUS[7:2];
  localparam logic [5:0] IDX_TRI    = REG_TRI_COUNT[7:2];
  localparam logic [5:0] IDX_VBASE  = REG_VERTEX_BASE[7:2];
  localparam logic [5:0] IDX_CBASE  = REG_COLOR_BASE[7:2];
  localparam logic [5:0] IDX_ID     = REG_ID[7:2];

  // Offsets above 0xFF or past the ID register are unmapped
  function automatic logic addr_mapped(input logic [SADDR_WIDTH-1:0] a);
    return ((a >> 8) == '0) && (a[7:2] <= IDX_ID);
  endfunction

  logic                   en_q;
  logic                   aw_held_q;
  logic [SADDR_WIDTH-1:0] awaddr_q;
  logic                   w_held_q;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic                   bvalid_q;
  axi_resp_e              bresp_q;
  logic                   rvalid_q;
  logic [31:0]            rdata_q, rdata_d;
  axi_resp_e              rresp_q, rresp_d;
  logic                   irq_en_q;
  logic [31:0]            tri_count_q, vbase_q, cbase_q;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   frame_start_q, frame_start_d;
  logic                   irq_q;

  logic       aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [5:0] wr_idx;
  logic       start_req, done_clr;

  wire unused_prot = ^{awprot_i, arprot_i};

  // Ready outputs stay low while reset is held and only rise once it lifts
  assign awready_o = en_q & ~aw_held_q & ~bvalid_q;
  assign wready_o  = en_q & ~w_held_q  & ~bvalid_q;
  assign arready_o = en_q & ~rvalid_q;

  assign aw_hs  = awvalid_i & awready_o;
  assign w_hs   = wvalid_i  & wready_o;
  assign ar_hs  = arvalid_i & arready_o;
  assign commit = aw_held_q & w_held_q;
  assign wr_idx = awaddr_q[7:2];
  assign wr_en  = commit & addr_mapped(awaddr_q);

  assign start_req = wr_en & (wr_idx == IDX_CTRL)   & wstrb_q[0] & wdata_q[CTRL_START_BIT];
  assign done_clr  = wr_en & (wr_idx == IDX_STATUS) & wstrb_q[0] & wdata_q[STATUS_DONE_BIT];

  assign bresp_o            = bresp_q;
  assign bvalid_o           = bvalid_q;
  assign rdata_o            = rdata_q;
  assign rresp_o            = rresp_q;
  assign rvalid_o           = rvalid_q;
  assign frame_start_o      = frame_start_q;
  assign triangles_count_o  = tri_count_q;
  assign base_addr_vertex_o = vbase_q[MADDR_WIDTH-1:0];
  assign base_addr_color_o  = cbase_q[MADDR_WIDTH-1:0];
  assign irq_o              = irq_q;

  // Out-of-reset flag gating the ready outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) en_q <= 1'b0;
    else         en_q <= 1'b1;
  end

  // Write-address hold register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
    end else if (aw_hs) begin
      aw_held_q <= 1'b1;
      awaddr_q  <= awaddr_i;
    end else if (commit) begin
      aw_held_q <= 1'b0;
    end
  end

  // Write-data hold register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_held_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (w_hs) begin
      w_held_q <= 1'b1;
      wdata_q  <= wdata_i;
      wstrb_q  <= wstrb_i;
    end else if (commit) begin
      w_held_q <= 1'b0;
    end
  end

  // Write response: raised by the commit, held until accepted
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= AXI_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= addr_mapped(awaddr_q) ? AXI_OKAY : AXI_SLVERR;
    end else if (bvalid_q && bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read mux on the incoming read address
  always_comb begin
    rdata_d = '0;
    rresp_d = AXI_SLVERR;
    if (addr_mapped(araddr_i)) begin
      rresp_d = AXI_OKAY;
      case (araddr_i[7:2])
        IDX_CTRL:   rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        IDX_STATUS: begin
          rdata_d[STATUS_BUSY_BIT] = busy_q;
          rdata_d[STATUS_DONE_BIT] = done_q;
        end
        IDX_TRI:    rdata_d = tri_count_q;
        IDX_VBASE:  rdata_d = vbase_q;
        IDX_CBASE:  rdata_d = cbase_q;
        IDX_ID:     rdata_d = ID_VALUE;
        default:    ;
      endcase
    end
  end

  // Read response: registered on AR handshake, held until accepted
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  // Configuration registers updated on a mapped commit
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_en_q    <= 1'b0;
      tri_count_q <= '0;
      vbase_q     <= '0;
      cbase_q     <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        IDX_CTRL:  if (wstrb_q[0]) irq_en_q <= wdata_q[CTRL_IRQ_EN_BIT];
        IDX_TRI:   tri_count_q <= apply_wstrb(tri_count_q, wdata_q, wstrb_q);
        IDX_VBASE: vbase_q     <= apply_wstrb(vbase_q, wdata_q, wstrb_q);
        IDX_CBASE: cbase_q     <= apply_wstrb(cbase_q, wdata_q, wstrb_q);
        default:   ;
      endcase
    end
  end

  // Frame sequencing: W1C first, then frame_end, then START sees the result
  always_comb begin
    busy_d        = busy_q;
    done_d        = done_q;
    frame_start_d = 1'b0;
    if (done_clr) done_d = 1'b0;
    if (frame_end_i && busy_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (start_req && !busy_d) begin
      if (tri_count_q != '0) begin
        busy_d        = 1'b1;
        frame_start_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  // Frame state, launch pulse and registered interrupt
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_start_q <= frame_start_d;
      irq_q         <= done_q & irq_en_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_ctrl_regs
// Description : Scoreboard bench for gpu_ctrl_regs with a behavioural model of
//               the register map and frame sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        frame_start;
  logic        frame_end = 1'b0;
  logic [31:0] triangles_count;
  logic [31:0] base_addr_vertex;
  logic [31:0] base_addr_color;
  logic        irq;

  gpu_ctrl_regs dut (
    .clk_i(clk), .reset_i(reset),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .frame_start_o(frame_start), .frame_end_i(frame_end),
    .triangles_count_o(triangles_count), .base_addr_vertex_o(base_addr_vertex),
    .base_addr_color_o(base_addr_color), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_tri = 0, m_vb = 0, m_cb = 0;
  bit m_irq_en = 0, m_busy = 0, m_done = 0;
  int m_starts = 0;
  int seen_starts = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0] bq[$];
  rexp_t      rq[$];

  function automatic bit mapped(input logic [31:0] a);
    return (a >> 2) < 6;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r, mask;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        mask = 32'hFF << (8 * b);
        r = (r & ~mask) | (d & mask);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a >> 2)
      0: return {30'd0, m_irq_en, 1'b0};
      1: return {30'd0, m_done, m_busy};
      2: return m_tri;
      3: return m_vb;
      4: return m_cb;
      5: return 32'h4753_0001;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a >> 2)
      0: if (s[0]) begin
           m_irq_en = d[1];
           if (d[0] && !m_busy) begin
             if (m_tri != 0) begin m_busy = 1; m_starts++; end
             else m_done = 1;
           end
         end
      1: if (s[0] && d[1]) m_done = 0;
      2: m_tri = merge(m_tri, d, s);
      3: m_vb  = merge(m_vb, d, s);
      4: m_cb  = merge(m_cb, d, s);
      default: ;
    endcase
  endtask

  task automatic model_fe();
    if (m_busy) begin m_busy = 0; m_done = 1; end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic       prev_bstall, prev_rstall, prev_fs, prev_bvalid;
    logic [1:0] prev_bresp, prev_rresp;
    logic [31:0] prev_rdata;
    logic [1:0] eb;
    rexp_t      er;
    prev_bstall = 0; prev_rstall = 0; prev_fs = 0; prev_bvalid = 0;
    prev_bresp = 0; prev_rresp = 0; prev_rdata = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_bstall = 0; prev_rstall = 0; prev_fs = 0; prev_bvalid = 0;
      end else begin
        if (prev_bstall) chk("b_hold", {bvalid, bresp}, {1'b1, prev_bresp});
        if (bvalid && bready) begin
          if (bq.size() == 0) chk("b_unexpected", 1, 0);
          else begin eb = bq.pop_front(); chk("bresp", bresp, eb); end
        end
        prev_bstall = bvalid && !bready;
        prev_bresp  = bresp;

        if (prev_rstall) chk("r_hold", {rvalid, rresp, rdata}, {1'b1, prev_rresp, prev_rdata});
        if (rvalid && rready) begin
          if (rq.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            er = rq.pop_front();
            chk("rdata", rdata, er.data);
            chk("rresp", rresp, er.resp);
          end
        end
        prev_rstall = rvalid && !rready;
        prev_rresp  = rresp;
        prev_rdata  = rdata;

        if (frame_start) begin
          seen_starts++;
          chk("fs_width", prev_fs, 0);
          chk("fs_with_bvalid", {bvalid, prev_bvalid}, 2'b10);
        end
        prev_fs     = frame_start;
        prev_bvalid = bvalid;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_outputs();
    chk("starts", seen_starts, m_starts);
    chk("irq", irq, m_done & m_irq_en);
    chk("tri_out", triangles_count, m_tri);
    chk("vbase_out", base_addr_vertex, m_vb);
    chk("cbase_out", base_addr_color, m_cb);
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int w_lead, input int b_delay, input bit fe_race);
    int n;
    bit awd, wd, awf, wf;
    bq.push_back(mapped(a) ? 2'b00 : 2'b10);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; wvalid = 1; awvalid = (w_lead == 0);
    bready = (b_delay == 0);
    n = 0; awd = 0; wd = 0;
    while (!(awd && wd) && n < 40) begin
      awf = awvalid && awready;
      wf  = wvalid && wready;
      @(negedge clk);
      n++;
      if (awf) begin awvalid = 0; awd = 1; end
      if (wf)  begin wvalid = 0;  wd = 1;  end
      if (!awd && !awvalid && n >= w_lead) awvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake_timeout", {awd, wd}, 2'b11);
    if (fe_race) begin
      // frame_end high across the commit edge
      frame_end = 1;
      @(negedge clk);
      frame_end = 0;
      if ((a >> 2) == 1) begin model_write(a, d, s); model_fe(); end
      else begin model_fe(); model_write(a, d, s); end
    end else begin
      model_write(a, d, s);
    end
    repeat (b_delay) @(negedge clk);
    bready = 1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_timeout", bvalid, 1);
    @(negedge clk);
    bready = 0;
    check_outputs();
  endtask

  task automatic axi_rd(input logic [31:0] a, input int r_delay);
    rexp_t e;
    int n;
    bit arf;
    e.data = mapped(a) ? model_read(a) : 32'd0;
    e.resp = mapped(a) ? 2'b00 : 2'b10;
    rq.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1; rready = (r_delay == 0);
    n = 0; arf = 0;
    while (!arf && n < 20) begin arf = arready; @(negedge clk); n++; end
    arvalid = 0;
    chk("ar_timeout", arf, 1);
    chk("r_latency", rvalid, 1);
    repeat (r_delay) @(negedge clk);
    rready = 1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rready = 0;
  endtask

  task automatic pulse_fe();
    @(negedge clk);
    frame_end = 1;
    @(negedge clk);
    frame_end = 0;
    model_fe();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_state();
    chk("rst_ctl_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, frame_start, irq}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tri", triangles_count, 0);
    chk("rst_bases", {base_addr_vertex, base_addr_color}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] a, d;
    int n;
    bit awf;

    #2 check_reset_state();
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", {awready, wready, arready}, 3'b111);

    // configure and start
    axi_wr(32'h08, 32'd5, 4'hF, 0, 0, 0);
    axi_wr(32'h0C, 32'h1000_0000, 4'hF, 0, 0, 0);
    axi_wr(32'h10, 32'h2000_0000, 4'hF, 0, 0, 0);
    axi_wr(32'h00, 32'h3, 4'hF, 0, 0, 0);
    axi_rd(32'h04, 0);
    pulse_fe();
    axi_rd(32'h04, 0);
    axi_wr(32'h04, 32'h2, 4'hF, 0, 0, 0);

    // zero triangle count
    axi_wr(32'h08, 32'd0, 4'hF, 0, 0, 0);
    axi_wr(32'h00, 32'h1, 4'hF, 0, 0, 0);
    axi_rd(32'h04, 0);

    // byte strobes
    axi_wr(32'h0C, 32'h0, 4'hF, 0, 0, 0);
    axi_wr(32'h0C, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    axi_rd(32'h0C, 0);

    // decoupled channels and backpressure
    axi_wr(32'h08, 32'd7, 4'hF, 3, 4, 0);
    axi_rd(32'h14, 3);
    axi_wr(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);

    // unmapped accesses
    axi_wr(32'h40, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_rd(32'h18, 0);
    axi_rd(32'h108, 2);

    // races
    axi_wr(32'h00, 32'h3, 4'hF, 0, 0, 0);
    axi_wr(32'h04, 32'h2, 4'hF, 0, 0, 1);
    axi_rd(32'h04, 0);
    axi_wr(32'h00, 32'h1, 4'hF, 0, 0, 0);
    axi_wr(32'h00, 32'h1, 4'hF, 1, 1, 0);
    axi_wr(32'h00, 32'h3, 4'hF, 0, 0, 1);
    axi_rd(32'h04, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a + 32'h100;
      d  = $urandom;
      if (op <= 4) axi_wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else if (op <= 7) axi_rd(a, $urandom_range(0, 3));
      else if (op == 8) pulse_fe();
      else @(negedge clk);
    end

    // reset between the AW and W handshakes
    axi_wr(32'h08, 32'd9, 4'hF, 0, 0, 0);
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1;
    n = 0; awf = 0;
    while (!awf && n < 20) begin awf = awready; @(negedge clk); n++; end
    awvalid = 0;
    chk("aw_only_timeout", awf, 1);
    reset = 1;
    #2 check_reset_state();
    repeat (2) @(negedge clk);
    check_reset_state();
    m_tri = 0; m_vb = 0; m_cb = 0; m_irq_en = 0; m_busy = 0; m_done = 0;
    reset = 0;
    @(negedge clk);
    axi_wr(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_rd(32'h08, 0);
    axi_rd(32'h0C, 0);
    axi_rd(32'h04, 0);

    repeat (3) @(negedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
